// File: rtl/ex_mdu_pkg.sv
// ex_mdu_pkg: opcode encodings, FSM state constants and opcode helpers for the multiply/divide unit.
package ex_mdu_pkg;
    localparam int MDU_OP_W = 3;
    localparam logic [MDU_OP_W-1:0] OP_MULT = 3'd0, OP_MULTU = 3'd1, OP_DIV = 3'd2, OP_DIVU = 3'd3,
                                    OP_MTHI = 3'd4, OP_MTLO = 3'd5;
    localparam logic [1:0] S_IDLE = 2'd0, S_BUSY = 2'd1, S_DONE = 2'd2;

    function automatic logic is_md(input logic [MDU_OP_W-1:0] op);
        return op < OP_MTHI;
    endfunction

    function automatic logic is_signed_op(input logic [MDU_OP_W-1:0] op);
        return op == OP_MULT || op == OP_DIV;
    endfunction
endpackage

// File: rtl/ex_mdu_if.sv
// ex_mdu_if: EX-stage request/response bundle between the pipeline and the multiply/divide unit.
interface ex_mdu_if #(parameter int DATA_W = 32) ();
    import ex_mdu_pkg::*;
    logic                op_valid;
    logic [MDU_OP_W-1:0] op;
    logic [DATA_W-1:0]   src_a;
    logic [DATA_W-1:0]   src_b;
    logic                cancel;
    logic                stall_req;
    logic                busy;
    logic                done;
    logic [DATA_W-1:0]   hi_o;
    logic [DATA_W-1:0]   lo_o;
    modport master (output op_valid, op, src_a, src_b, cancel, input stall_req, busy, done, hi_o, lo_o);
    modport slave (input op_valid, op, src_a, src_b, cancel, output stall_req, busy, done, hi_o, lo_o);
endinterface

// File: rtl/ex_mdu_div.sv
// ex_mdu_div: iterative unsigned restoring divider, one quotient bit per step.
// Outputs show the partial result after the current step, so the last step's result is usable at the same edge.
module ex_mdu_div #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic              i_step,
    input  logic [DATA_W-1:0] i_dividend,
    input  logic [DATA_W-1:0] i_divisor,
    output logic [DATA_W-1:0] o_quotient,
    output logic [DATA_W-1:0] o_remainder
);
    logic [DATA_W-1:0] r_rem, r_quo, r_div, w_shift;
    logic [DATA_W:0]   w_diff;

    assign w_shift     = {r_rem[DATA_W-2:0], r_quo[DATA_W-1]};
    assign w_diff      = {r_rem, r_quo[DATA_W-1]} - {1'b0, r_div};
    assign o_remainder = w_diff[DATA_W] ? w_shift : w_diff[DATA_W-1:0];
    assign o_quotient  = {r_quo[DATA_W-2:0], ~w_diff[DATA_W]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rem <= '0;
            r_quo <= '0;
            r_div <= '0;
        end else if (i_start) begin
            r_rem <= '0;
            r_quo <= i_dividend;
            r_div <= i_divisor;
        end else if (i_step) begin
            r_rem <= o_remainder;
            r_quo <= o_quotient;
        end
    end
endmodule

// File: rtl/ex_mdu.sv
// ex_mdu: multi-cycle MULT/MULTU/DIV/DIVU unit owning HI/LO, with MTHI/MTLO writes and a pipeline stall request.
module ex_mdu
    import ex_mdu_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int MUL_LAT = 2
) (
    input logic clk,
    input logic rst,
    ex_mdu_if.slave bus
);
    localparam int CNT_W = $clog2(DATA_W + 1);

    logic [1:0]          r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_is_div, r_signed, r_neg_q, r_neg_r, r_dz;
    logic [DATA_W-1:0]   r_a, r_b, r_hi, r_lo;
    logic                w_idle_op, w_start, w_last, w_sa, w_sb;
    logic [DATA_W-1:0]   w_mag_a, w_mag_b, w_quo, w_rem, w_res_hi, w_res_lo;
    logic [2*DATA_W-1:0] w_ext_a, w_ext_b, w_prod;

    assign w_idle_op = r_state == S_IDLE && bus.op_valid && !bus.cancel;
    assign w_start   = w_idle_op && is_md(bus.op);
    assign w_sa      = is_signed_op(bus.op) && bus.src_a[DATA_W-1];
    assign w_sb      = is_signed_op(bus.op) && bus.src_b[DATA_W-1];
    assign w_mag_a   = w_sa ? -bus.src_a : bus.src_a;
    assign w_mag_b   = w_sb ? -bus.src_b : bus.src_b;
    assign w_last    = r_state == S_BUSY && r_cnt == CNT_W'(1);

    ex_mdu_div #(.DATA_W(DATA_W)) u_div (
        .clk        (clk),
        .rst        (rst),
        .i_start    (w_start && bus.op[1]),
        .i_step     (r_state == S_BUSY && r_is_div),
        .i_dividend (w_mag_a),
        .i_divisor  (w_mag_b),
        .o_quotient (w_quo),
        .o_remainder(w_rem)
    );

    // Sign-extending both operands to 2*DATA_W makes one multiplier serve MULT and MULTU.
    assign w_ext_a  = {{DATA_W{r_signed & r_a[DATA_W-1]}}, r_a};
    assign w_ext_b  = {{DATA_W{r_signed & r_b[DATA_W-1]}}, r_b};
    assign w_prod   = w_ext_a * w_ext_b;
    assign w_res_lo = !r_is_div ? w_prod[DATA_W-1:0] : r_dz ? '1 : r_neg_q ? -w_quo : w_quo;
    assign w_res_hi = !r_is_div ? w_prod[2*DATA_W-1:DATA_W] : r_neg_r ? -w_rem : w_rem;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_is_div <= 1'b0;
            r_signed <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_dz     <= 1'b0;
            r_a      <= '0;
            r_b      <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else if (bus.cancel) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            if (w_start) begin
                r_state  <= S_BUSY;
                r_cnt    <= bus.op[1] ? CNT_W'(DATA_W) : CNT_W'(MUL_LAT);
                r_is_div <= bus.op[1];
                r_signed <= is_signed_op(bus.op);
                r_neg_q  <= w_sa ^ w_sb;
                r_neg_r  <= w_sa;
                r_dz     <= bus.src_b == '0;
                r_a      <= bus.src_a;
                r_b      <= bus.src_b;
            end else if (w_idle_op && bus.op == OP_MTHI) begin
                r_hi <= bus.src_a;
            end else if (w_idle_op && bus.op == OP_MTLO) begin
                r_lo <= bus.src_a;
            end
            if (r_state == S_BUSY) begin
                r_cnt <= r_cnt - CNT_W'(1);
                if (w_last) begin
                    r_state <= S_DONE;
                    r_hi    <= w_res_hi;
                    r_lo    <= w_res_lo;
                end
            end
            if (r_state == S_DONE) r_state <= S_IDLE;
        end
    end

    assign bus.stall_req = w_start || r_state == S_BUSY;
    assign bus.busy      = r_state == S_BUSY;
    assign bus.done      = r_state == S_DONE;
    assign bus.hi_o      = r_hi;
    assign bus.lo_o      = r_lo;
endmodule

// File: doc/ex_mdu.md
# ex_mdu

Parametrised multiply/divide unit that sits beside the ALU in the EX stage. It executes MULT/MULTU/DIV/DIVU as multi-cycle operations and owns the architectural HI/LO registers. It writes them directly for MTHI/MTLO and exposes them for MFHI/MFLO. While an operation is in flight it raises a stall request into the pipeline stall controller, which freezes IF..EX through the `StallBus`.

## Interface
- DATA_W, 32: operand/HI/LO width (≥2).
- MUL_LAT, 2: cycles spent in BUSY for a multiply (≥1).
- clk  in  1  clock; single clock domain.
- rst  in  1  reset; synchronous, active-high.
- op_valid  in  1  EX holds a valid MDU instruction this cycle.
- op  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6–7 no-op.
- src_a  in  DATA_W  rs operand (dividend / multiplicand / MTxx data).
- src_b  in  DATA_W  rt operand (divisor / multiplier).
- cancel  in  1  flush: abort in-flight op.
- stall_req  out  1  hold pipeline; result not yet written.
- busy  out  1  state is BUSY.
- done  out  1  one-cycle pulse, HI/LO just updated by MULT/DIV.
- hi_o  out  DATA_W  current HI.
- lo_o  out  DATA_W  current LO.

## Operation
- States: IDLE, BUSY, DONE. Reset → IDLE, counter 0, HI=LO=0, all outputs 0.
- IDLE with op_valid and op∈{0..3}: latch operands and sign info, then go to BUSY. The counter loads MUL_LAT (mul) or DATA_W (div).
- IDLE with op_valid and op 4/5: write HI/LO from src_a at the clock edge. No stall; stay IDLE.
- BUSY: decrement the counter each cycle. The divider does one restoring step per cycle. On the cycle the counter reaches 1, write HI/LO and go to DONE.
- DONE: done=1, stall_req=0. op_valid is ignored, because EX still presents the same instruction. Next state is IDLE, so a back-to-back MDU op is accepted the cycle after DONE.
- stall_req = (IDLE & op_valid & op∈{0..3} & !cancel) | BUSY. It is combinational in the accept cycle.
- Multiply: signed or unsigned full 2·DATA_W product. HI=upper half, LO=lower half.
- Divide: operate on magnitudes (unsigned, DATA_W bits).
  - Quotient is negated if the operand signs differ.
  - Remainder takes the sign of the dividend.
  - LO=quotient, HI=remainder.
- Divide by zero (decided): LO=all-ones, HI=dividend. This still takes the full DATA_W cycles.
- Signed overflow (−2^(W−1) / −1): LO=0x80000000, HI=0. This falls out of the magnitude method.
- cancel: from any state, go to IDLE next edge, with no HI/LO write and no done pulse. cancel beats a simultaneous start or MTxx. MTxx while cancel is high is dropped.
- rst beats cancel and everything else, including mid-BUSY.

## Timing
- Div: accept cycle plus DATA_W BUSY cycles give stall_req high for DATA_W+1 cycles (33 at default). DONE follows, and new HI/LO are visible on hi_o/lo_o in the DONE cycle.
- Mul: stall_req high for MUL_LAT+1 cycles, then DONE.
- MTHI/MTLO: value visible on hi_o/lo_o the cycle after the accept.
- hi_o/lo_o are registered. There is no same-cycle bypass; EX forwarding is not this block's job.

## Structure
- Opcode constants (`MduMult … `MduMtlo) and MDU_OP_W=3 go in lib/defines.vh. Widen `StallBus` users only via the existing stall controller input.
- Sub-module mdu_div: iterative unsigned restoring divider, DATA_W-parametrised.
  - Ports: start, dividend, divisor, quotient, remainder, step.
  - ex_mdu owns the FSM, sign fix-up and multiply.
- Counter width $clog2(DATA_W+1).

## Test plan
- DIVU 100/7 → stall_req high 33 cycles, done pulse, LO=14, HI=2.
- DIV 0xFFFFFFF9 (−7) / 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- MULT 0xFFFFFFFF×2 → HI=0xFFFFFFFF, LO=0xFFFFFFFE. MULTU same operands → HI=1, LO=0xFFFFFFFE, stall 3 cycles.
- DIVU 5/0 → LO=0xFFFFFFFF, HI=5. DIV 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
- MTHI 0x1234 then DIVU started, cancel at BUSY cycle 10 → stall_req low next cycle, HI=0x1234, no done.
- Back-to-back MULTU 3×4 then DIVU 13/4 with op_valid held through DONE → exactly two operations, final LO=3, HI=1. rst asserted mid-BUSY → HI=LO=0, IDLE.
